sbox_seq: RTL and testbench

//  Time-multiplexed controller for the eight DES S-boxes (S1..S8) in the round function.
//  - Accepts one 48-bit post-XOR word (E(R) xor K) per transaction.
//  - Evaluates the word in LOOKUPS groups per clock.
//  - Returns the 32-bit concatenated S-box result on a valid/ready handshake.
//  - Sits between the key-mix XOR and the P permutation; trades latency for area/timing.

---
 rtl/sbox_seq.sv | 173 +++++++++++++++++
 tb/tb_sbox_seq.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sbox_seq.sv
// Time-multiplexed DES S-box evaluator: LOOKUPS S-box lanes per cycle, 8/LOOKUPS cycles per 48->32 bit word.
// Optional synchronous abort input is enabled with `define SBOX_SEQ_ABORT_EN.
module sbox_seq #(
  parameter int LOOKUPS = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [47:0] data_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] data_out,
  output logic        busy
`ifdef SBOX_SEQ_ABORT_EN
  ,
  input  logic        abort
`endif
);

  // Handshake: a word moves on in_valid && in_ready (IDLE only); a result moves on
  // out_valid && out_ready (DONE only); data_out is held stable while out_ready is low.

  generate
    if (LOOKUPS != 1 && LOOKUPS != 2 && LOOKUPS != 4 && LOOKUPS != 8) begin : g_bad_lookups
      $error("sbox_seq: LOOKUPS must be 1, 2, 4 or 8");
    end
  endgenerate

  // Each table is 64 nibbles, row-major (row*16+col), entry 0 in the top nibble.
  localparam logic [255:0] S1_TAB = 256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D;
  localparam logic [255:0] S2_TAB = 256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9;
  localparam logic [255:0] S3_TAB = 256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C;
  localparam logic [255:0] S4_TAB = 256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E;
  localparam logic [255:0] S5_TAB = 256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453;
  localparam logic [255:0] S6_TAB = 256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D;
  localparam logic [255:0] S7_TAB = 256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF689502_6BD814A7950FE23C;
  localparam logic [255:0] S8_TAB = 256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state, state_n;
  logic [2:0]  idx;
  logic [47:0] word_q;
  logic [31:0] result_q;
  logic [31:0] result_nxt;
  logic [31:0] data_out_q;
  logic        last_step;
  logic        abort_req;

`ifdef SBOX_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // box is 0-based (0 = S1); row = {b6,b1}, column = {b5..b2}.
  function automatic logic [3:0] sbox_lookup(input logic [2:0] box, input logic [5:0] six);
    logic [255:0] tab;
    logic [5:0]   pos;
    case (box)
      3'd0:    tab = S1_TAB;
      3'd1:    tab = S2_TAB;
      3'd2:    tab = S3_TAB;
      3'd3:    tab = S4_TAB;
      3'd4:    tab = S5_TAB;
      3'd5:    tab = S6_TAB;
      3'd6:    tab = S7_TAB;
      default: tab = S8_TAB;
    endcase
    pos = {six[5], six[0], six[4:1]};
    return tab[8'd255 - {pos, 2'b00} -: 4];
  endfunction

  logic [2:0] lane_box [LOOKUPS];
  logic [3:0] lane_nib [LOOKUPS];

  generate
    for (genvar j = 0; j < LOOKUPS; j++) begin : g_lane
      logic [5:0] fpos;
      logic [5:0] field;
      assign lane_box[j] = idx + 3'(j);
      // S(box+1) field starts at bit 47 - 6*box of the 0-based captured word.
      assign fpos        = 6'd47 - (6'({lane_box[j], 2'b00}) + 6'({lane_box[j], 1'b0}));
      assign field       = word_q[fpos -: 6];
      assign lane_nib[j] = sbox_lookup(lane_box[j], field);
    end
  endgenerate

  always_comb begin
    result_nxt = result_q;
    for (int j = 0; j < LOOKUPS; j++) begin
      result_nxt[5'd31 - {lane_box[j], 2'b00} -: 4] = lane_nib[j];
    end
  end

  assign last_step = (4'(idx) + 4'(LOOKUPS)) == 4'd8;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (in_valid) state_n = RUN;
      RUN: begin
        if (abort_req)      state_n = IDLE;
        else if (last_step) state_n = DONE;
      end
      DONE: begin
        if (abort_req)      state_n = IDLE;
        else if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == RUN) || (state == DONE);
  end

  assign data_out = data_out_q;

  // data_out_q only loads on completion so the last result survives the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= 3'd0;
      word_q     <= 48'd0;
      result_q   <= 32'd0;
      data_out_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            word_q   <= data_in;
            idx      <= 3'd0;
            result_q <= 32'd0;
          end
        end
        RUN: begin
          if (abort_req) begin
            idx      <= 3'd0;
            result_q <= 32'd0;
          end else begin
            result_q <= result_nxt;
            if (last_step) begin
              idx        <= 3'd0;
              data_out_q <= result_nxt;
            end else begin
              idx <= idx + 3'(LOOKUPS);
            end
          end
        end
        DONE: begin
          if (abort_req) result_q <= 32'd0;
        end
        default: idx <= 3'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_sbox_seq.sv
// Directed bench for sbox_seq: three instances (LOOKUPS = 1, 2, 8) on one clock and reset.
// Abort scenarios are compiled in when SBOX_SEQ_ABORT_EN is defined.
module tb_sbox_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid1, in_ready1, out_valid1, out_ready1, busy1, abort1;
  logic [47:0] data_in1;
  logic [31:0] data_out1;
  logic        in_valid2, in_ready2, out_valid2, out_ready2, busy2, abort2;
  logic [47:0] data_in2;
  logic [31:0] data_out2;
  logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8, abort8;
  logic [47:0] data_in8;
  logic [31:0] data_out8;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] EXP_ZERO  = 32'hEFA72C4D;
  localparam logic [31:0] EXP_ONES  = 32'hD9CE3DCB;
  localparam logic [31:0] EXP_ROW1  = 32'h03DDEAD1;
  localparam logic [31:0] EXP_ROW2  = 32'h40DA4917;
  localparam logic [31:0] EXP_MIXED = 32'hE9CE3DCB;

  sbox_seq #(.LOOKUPS(1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1), .data_in(data_in1),
    .out_valid(out_valid1), .out_ready(out_ready1), .data_out(data_out1), .busy(busy1)
`ifdef SBOX_SEQ_ABORT_EN
    , .abort(abort1)
`endif
  );

  sbox_seq #(.LOOKUPS(2)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2), .data_in(data_in2),
    .out_valid(out_valid2), .out_ready(out_ready2), .data_out(data_out2), .busy(busy2)
`ifdef SBOX_SEQ_ABORT_EN
    , .abort(abort2)
`endif
  );

  sbox_seq #(.LOOKUPS(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .data_in(data_in8),
    .out_valid(out_valid8), .out_ready(out_ready8), .data_out(data_out8), .busy(busy8)
`ifdef SBOX_SEQ_ABORT_EN
    , .abort(abort8)
`endif
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic test_reset;
    in_valid1 = 0; out_ready1 = 0; data_in1 = '0; abort1 = 0;
    in_valid2 = 0; out_ready2 = 0; data_in2 = '0; abort2 = 0;
    in_valid8 = 0; out_ready8 = 0; data_in8 = '0; abort8 = 0;
    rst_n = 0;
    repeat (2) tick;
    checks++;
    if ({out_valid8, out_valid2, out_valid1} !== 3'b000) begin
      errors++; $display("FAIL reset_out_valid: got %b expected 000", {out_valid8, out_valid2, out_valid1});
    end
    checks++;
    if ({busy8, busy2, busy1} !== 3'b000) begin
      errors++; $display("FAIL reset_busy: got %b expected 000", {busy8, busy2, busy1});
    end
    checks++;
    if ({in_ready8, in_ready2, in_ready1} !== 3'b111) begin
      errors++; $display("FAIL reset_in_ready: got %b expected 111", {in_ready8, in_ready2, in_ready1});
    end
    checks++;
    if (data_out1 !== 32'd0 || data_out2 !== 32'd0 || data_out8 !== 32'd0) begin
      errors++; $display("FAIL reset_data_out: got %h %h %h expected 0", data_out1, data_out2, data_out8);
    end
    rst_n = 1;
    tick;
  endtask

  // LOOKUPS=1: one word through, 8 cycles accept -> out_valid, out_ready already high.
  task automatic test_lookups1(input logic [47:0] word, input logic [31:0] exp, input string name);
    int cnt;
    data_in1 = word; in_valid1 = 1; out_ready1 = 1;
    checks++;
    if (in_ready1 !== 1'b1) begin
      errors++; $display("FAIL %s_in_ready: got %b expected 1", name, in_ready1);
    end
    tick;
    in_valid1 = 0; data_in1 = ~word;
    checks++;
    if (busy1 !== 1'b1 || in_ready1 !== 1'b0) begin
      errors++; $display("FAIL %s_run: busy %b in_ready %b expected 1 0", name, busy1, in_ready1);
    end
    cnt = 0;
    while (out_valid1 !== 1'b1 && cnt < 20) begin
      tick; cnt++;
    end
    checks++;
    if (cnt != 8) begin
      errors++; $display("FAIL %s_latency: got %0d cycles expected 8", name, cnt);
    end
    checks++;
    if (data_out1 !== exp) begin
      errors++; $display("FAIL %s_data: got %h expected %h", name, data_out1, exp);
    end
    tick;
    checks++;
    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1 || busy1 !== 1'b0) begin
      errors++; $display("FAIL %s_idle: out_valid %b in_ready %b busy %b expected 0 1 0",
                         name, out_valid1, in_ready1, busy1);
    end
    checks++;
    if (data_out1 !== exp) begin
      errors++; $display("FAIL %s_hold: got %h expected %h", name, data_out1, exp);
    end
  endtask

  task automatic test_lookups8_stall;
    data_in8 = 48'h0; in_valid8 = 1; out_ready8 = 0;
    tick;
    data_in8 = 48'hFFFFFFFFFFFF;
    checks++;
    if (out_valid8 !== 1'b0 || busy8 !== 1'b1) begin
      errors++; $display("FAIL l8_run: out_valid %b busy %b expected 0 1", out_valid8, busy8);
    end
    tick;
    checks++;
    if (out_valid8 !== 1'b1) begin
      errors++; $display("FAIL l8_latency: out_valid %b expected 1 one cycle after accept", out_valid8);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid8 !== 1'b1 || in_ready8 !== 1'b0 || data_out8 !== EXP_ZERO) begin
        errors++; $display("FAIL l8_stall_%0d: out_valid %b in_ready %b data %h expected 1 0 %h",
                           i, out_valid8, in_ready8, data_out8, EXP_ZERO);
      end
      tick;
    end
    in_valid8 = 0; out_ready8 = 1;
    #1;
    checks++;
    if (in_ready8 !== 1'b0 || out_valid8 !== 1'b1) begin
      errors++; $display("FAIL l8_done_ready: in_ready %b out_valid %b expected 0 1", in_ready8, out_valid8);
    end
    tick;
    checks++;
    if (out_valid8 !== 1'b0 || in_ready8 !== 1'b1 || busy8 !== 1'b0 || data_out8 !== EXP_ZERO) begin
      errors++; $display("FAIL l8_idle: out_valid %b in_ready %b busy %b data %h expected 0 1 0 %h",
                         out_valid8, in_ready8, busy8, data_out8, EXP_ZERO);
    end
    out_ready8 = 0;
  endtask

  task automatic test_back_to_back;
    int cnt;
    data_in2 = 48'h0; in_valid2 = 1; out_ready2 = 1;
    tick;
    data_in2 = 48'hFFFFFFFFFFFF;
    cnt = 0;
    while (out_valid2 !== 1'b1 && cnt < 20) begin
      tick; cnt++;
    end
    checks++;
    if (cnt != 4 || data_out2 !== EXP_ZERO) begin
      errors++; $display("FAIL b2b_first: %0d cycles data %h expected 4 %h", cnt, data_out2, EXP_ZERO);
    end
    tick;
    checks++;
    if (in_ready2 !== 1'b1 || out_valid2 !== 1'b0) begin
      errors++; $display("FAIL b2b_gap: in_ready %b out_valid %b expected 1 0", in_ready2, out_valid2);
    end
    tick;
    in_valid2 = 0;
    checks++;
    if (busy2 !== 1'b1 || in_ready2 !== 1'b0) begin
      errors++; $display("FAIL b2b_second_accept: busy %b in_ready %b expected 1 0", busy2, in_ready2);
    end
    cnt = 0;
    while (out_valid2 !== 1'b1 && cnt < 20) begin
      tick; cnt++;
    end
    checks++;
    if (cnt != 4 || data_out2 !== EXP_ONES) begin
      errors++; $display("FAIL b2b_second: %0d cycles data %h expected 4 %h", cnt, data_out2, EXP_ONES);
    end
    tick;
    out_ready2 = 0;
  endtask

`ifdef SBOX_SEQ_ABORT_EN
  task automatic test_abort;
    int cnt;
    logic seen;
    data_in1 = 48'h0; in_valid1 = 1; out_ready1 = 1; abort1 = 0;
    tick;
    in_valid1 = 0;
    repeat (3) tick;
    checks++;
    if (busy1 !== 1'b1 || out_valid1 !== 1'b0) begin
      errors++; $display("FAIL abort_pre: busy %b out_valid %b expected 1 0", busy1, out_valid1);
    end
    abort1 = 1;
    tick;
    abort1 = 0;
    checks++;
    if (busy1 !== 1'b0 || in_ready1 !== 1'b1 || out_valid1 !== 1'b0) begin
      errors++; $display("FAIL abort_idle: busy %b in_ready %b out_valid %b expected 0 1 0",
                         busy1, in_ready1, out_valid1);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (out_valid1 === 1'b1) seen = 1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++; $display("FAIL abort_no_output: out_valid rose %b expected 0", seen);
    end
    // abort in IDLE must not block an accept in the same cycle
    data_in1 = 48'hFFFFFFFFFFFF; in_valid1 = 1; out_ready1 = 0; abort1 = 1;
    tick;
    in_valid1 = 0; abort1 = 0;
    checks++;
    if (busy1 !== 1'b1) begin
      errors++; $display("FAIL abort_idle_accept: busy %b expected 1", busy1);
    end
    cnt = 0;
    while (out_valid1 !== 1'b1 && cnt < 20) begin
      tick; cnt++;
    end
    checks++;
    if (cnt != 8 || data_out1 !== EXP_ONES) begin
      errors++; $display("FAIL abort_after: %0d cycles data %h expected 8 %h", cnt, data_out1, EXP_ONES);
    end
    abort1 = 1; out_ready1 = 1;
    tick;
    abort1 = 0; out_ready1 = 0;
    checks++;
    if (out_valid1 !== 1'b0 || in_ready1 !== 1'b1) begin
      errors++; $display("FAIL abort_done: out_valid %b in_ready %b expected 0 1", out_valid1, in_ready1);
    end
  endtask
`endif

  task automatic test_reset_mid_run;
    int cnt;
    data_in1 = 48'h041041041041; in_valid1 = 1; out_ready1 = 1;
    tick;
    in_valid1 = 0;
    repeat (3) tick;
    rst_n = 0;
    #1;
    checks++;
    if (out_valid1 !== 1'b0 || busy1 !== 1'b0 || in_ready1 !== 1'b1 || data_out1 !== 32'd0) begin
      errors++; $display("FAIL rst_mid_run: out_valid %b busy %b in_ready %b data %h expected 0 0 1 0",
                         out_valid1, busy1, in_ready1, data_out1);
    end
    tick;
    rst_n = 1;
    tick;
    data_in1 = 48'h0; in_valid1 = 1;
    tick;
    in_valid1 = 0;
    cnt = 0;
    while (out_valid1 !== 1'b1 && cnt < 20) begin
      tick; cnt++;
    end
    checks++;
    if (cnt != 8 || data_out1 !== EXP_ZERO) begin
      errors++; $display("FAIL rst_recover: %0d cycles data %h expected 8 %h", cnt, data_out1, EXP_ZERO);
    end
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_lookups1(48'h000000000000, EXP_ZERO, "l1_zero");
    test_lookups1(48'hFFFFFFFFFFFF, EXP_ONES, "l1_ones");
    checks++;
    if (data_out1[11:8] !== 4'd13) begin
      errors++; $display("FAIL l1_s6_nibble: got %0d expected 13", data_out1[11:8]);
    end
    test_lookups1(48'h041041041041, EXP_ROW1, "l1_row1");
    test_lookups1(48'h820820820820, EXP_ROW2, "l1_row2");
    test_lookups1(48'h03FFFFFFFFFF, EXP_MIXED, "l1_mixed");
    test_lookups8_stall;
    test_back_to_back;
`ifdef SBOX_SEQ_ABORT_EN
    test_abort;
`endif
    test_reset_mid_run;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
